// File: rtl/sram_write_arbiter.sv
// Shares the scratchpad SRAM write port between frontend stores and backend DRAM fills, with anti-starvation forcing.
// One-cycle request-to-valid latency; a stalled slot (valid && !ready) holds its contents and withholds both readies.
module sram_write_arbiter #(
   parameter int XBAR_W        = 32,
   parameter int DATA_W        = 256,
   parameter int MAX_FE_STREAK = 4
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              fe_req_valid,
   output logic              fe_req_ready,
   input  logic              fe_row_or_col,
   input  logic [XBAR_W-1:0] fe_xbar,
   input  logic [DATA_W-1:0] fe_wdata,
   input  logic              be_req_valid,
   output logic              be_req_ready,
   input  logic              be_row_or_col,
   input  logic [XBAR_W-1:0] be_xbar,
   input  logic [DATA_W-1:0] be_wdata,
   input  logic              be_queue_full,
   output logic              sram_wr_valid,
   input  logic              sram_wr_ready,
   output logic              sram_wr_src,
   output logic              sram_row_or_col,
   output logic [XBAR_W-1:0] sram_xbar,
   output logic [DATA_W-1:0] sram_wdata,
   output logic [3:0]        fe_streak
);

   typedef struct packed {
      logic              row_or_col;
      logic [XBAR_W-1:0] xbar;
      logic [DATA_W-1:0] wdata;
   } wr_req_t;

   wr_req_t fe_req;
   wr_req_t be_req;
   wr_req_t slot;

   logic slot_free;
   logic be_force;
   logic fe_grant;
   logic be_grant;

   assign fe_req = '{row_or_col: fe_row_or_col, xbar: fe_xbar, wdata: fe_wdata};
   assign be_req = '{row_or_col: be_row_or_col, xbar: be_xbar, wdata: be_wdata};

   // A draining slot can be refilled in the same cycle, so no bubble between writes.
   assign slot_free = !sram_wr_valid || sram_wr_ready;
   assign be_force  = be_req_valid && (be_queue_full || (fe_streak >= 4'(MAX_FE_STREAK)));

   // Gated by n_rst so neither requester sees an accept while reset is asserted.
   assign fe_grant = n_rst && slot_free && fe_req_valid && !be_force;
   assign be_grant = n_rst && slot_free && be_req_valid && (be_force || !fe_req_valid);

   assign fe_req_ready = fe_grant;
   assign be_req_ready = be_grant;

   assign sram_row_or_col = slot.row_or_col;
   assign sram_xbar       = slot.xbar;
   assign sram_wdata      = slot.wdata;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         slot          <= '0;
         sram_wr_valid <= 1'b0;
         sram_wr_src   <= 1'b0;
         fe_streak     <= 4'd0;
      end else begin
         if (fe_grant || be_grant) begin
            slot          <= be_grant ? be_req : fe_req;
            sram_wr_valid <= 1'b1;
            sram_wr_src   <= be_grant;
         end else if (sram_wr_ready) begin
            sram_wr_valid <= 1'b0;
         end

         // Streak only counts frontend wins that made a waiting backend wait longer.
         if (fe_grant) begin
            if (be_req_valid)
               fe_streak <= (fe_streak == 4'hF) ? fe_streak : fe_streak + 4'd1;
            else
               fe_streak <= 4'd0;
         end else if (be_grant) begin
            fe_streak <= 4'd0;
         end
      end
   end

endmodule

// File: tb/tb_sram_write_arbiter.sv
// Directed-vector bench for sram_write_arbiter with default parameters (MAX_FE_STREAK=4).
module tb_sram_write_arbiter;

   logic         clk = 1'b0;
   logic         n_rst;
   logic         fe_req_valid, fe_req_ready, fe_row_or_col;
   logic [31:0]  fe_xbar;
   logic [255:0] fe_wdata;
   logic         be_req_valid, be_req_ready, be_row_or_col;
   logic [31:0]  be_xbar;
   logic [255:0] be_wdata;
   logic         be_queue_full;
   logic         sram_wr_valid, sram_wr_ready, sram_wr_src, sram_row_or_col;
   logic [31:0]  sram_xbar;
   logic [255:0] sram_wdata;
   logic [3:0]   fe_streak;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   sram_write_arbiter dut (
      .clk(clk), .n_rst(n_rst),
      .fe_req_valid(fe_req_valid), .fe_req_ready(fe_req_ready), .fe_row_or_col(fe_row_or_col),
      .fe_xbar(fe_xbar), .fe_wdata(fe_wdata),
      .be_req_valid(be_req_valid), .be_req_ready(be_req_ready), .be_row_or_col(be_row_or_col),
      .be_xbar(be_xbar), .be_wdata(be_wdata), .be_queue_full(be_queue_full),
      .sram_wr_valid(sram_wr_valid), .sram_wr_ready(sram_wr_ready), .sram_wr_src(sram_wr_src),
      .sram_row_or_col(sram_row_or_col), .sram_xbar(sram_xbar), .sram_wdata(sram_wdata),
      .fe_streak(fe_streak)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive inputs at the falling edge, settle, leaving time for combinational checks.
   task automatic drive(input logic fv, input logic bv, input logic full, input logic rdy,
                        input logic [31:0] fx, input logic [31:0] bx);
      @(negedge clk);
      fe_req_valid  = fv;
      be_req_valid  = bv;
      be_queue_full = full;
      sram_wr_ready = rdy;
      fe_xbar       = fx;
      be_xbar       = bx;
      fe_wdata      = {224'd0, ~fx};
      be_wdata      = {224'd0, ~bx};
      fe_row_or_col = fx[0];
      be_row_or_col = bx[0];
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        exp_be;
      logic [31:0] exp_x;
      logic [3:0]  exp_st;

      n_rst = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h55, 32'h66);
      check("rst_fe_ready", {31'd0, fe_req_ready}, 32'd0);
      check("rst_be_ready", {31'd0, be_req_ready}, 32'd0);
      tick();
      check("rst_valid", {31'd0, sram_wr_valid}, 32'd0);
      check("rst_xbar", sram_xbar, 32'd0);
      check("rst_streak", {28'd0, fe_streak}, 32'd0);
      check("rst_src", {31'd0, sram_wr_src}, 32'd0);
      @(negedge clk);
      n_rst = 1'b1;

      // Single frontend write
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h12, 32'h0);
      check("single_fe_ready", {31'd0, fe_req_ready}, 32'd1);
      check("single_be_ready", {31'd0, be_req_ready}, 32'd0);
      tick();
      check("single_valid", {31'd0, sram_wr_valid}, 32'd1);
      check("single_src", {31'd0, sram_wr_src}, 32'd0);
      check("single_xbar", sram_xbar, 32'h12);
      check("single_wdata", sram_wdata[31:0], ~32'h12);
      check("single_streak", {28'd0, fe_streak}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      tick();
      check("single_clear", {31'd0, sram_wr_valid}, 32'd0);

      // Starvation: F,F,F,F,B repeating
      for (int i = 0; i < 10; i++) begin
         exp_be = (i % 5 == 4);
         exp_x  = exp_be ? 32'h200 + i : 32'h100 + i;
         exp_st = exp_be ? 4'd0 : 4'((i % 5) + 1);
         drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h100 + i, 32'h200 + i);
         check($sformatf("starve_fe_rdy%0d", i), {31'd0, fe_req_ready}, {31'd0, !exp_be});
         check($sformatf("starve_be_rdy%0d", i), {31'd0, be_req_ready}, {31'd0, exp_be});
         tick();
         check($sformatf("starve_valid%0d", i), {31'd0, sram_wr_valid}, 32'd1);
         check($sformatf("starve_src%0d", i), {31'd0, sram_wr_src}, {31'd0, exp_be});
         check($sformatf("starve_xbar%0d", i), sram_xbar, exp_x);
         check($sformatf("starve_streak%0d", i), {28'd0, fe_streak}, {28'd0, exp_st});
      end

      // Queue full: three backend wins despite a fresh streak
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h300 + i, 32'h400 + i);
         check($sformatf("full_be_rdy%0d", i), {31'd0, be_req_ready}, 32'd1);
         check($sformatf("full_fe_rdy%0d", i), {31'd0, fe_req_ready}, 32'd0);
         tick();
         check($sformatf("full_src%0d", i), {31'd0, sram_wr_src}, 32'd1);
         check($sformatf("full_xbar%0d", i), sram_xbar, 32'h400 + i);
      end
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h500, 32'h600);
      check("full_drop_fe_rdy", {31'd0, fe_req_ready}, 32'd1);
      tick();
      check("full_drop_src", {31'd0, sram_wr_src}, 32'd0);
      check("full_drop_streak", {28'd0, fe_streak}, 32'd1);

      // Backpressure: slot frozen for 5 cycles
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h700 + i, 32'h800 + i);
         check($sformatf("bp_fe_rdy%0d", i), {31'd0, fe_req_ready}, 32'd0);
         check($sformatf("bp_be_rdy%0d", i), {31'd0, be_req_ready}, 32'd0);
         tick();
         check($sformatf("bp_valid%0d", i), {31'd0, sram_wr_valid}, 32'd1);
         check($sformatf("bp_xbar%0d", i), sram_xbar, 32'h500);
         check($sformatf("bp_src%0d", i), {31'd0, sram_wr_src}, 32'd0);
      end
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h900, 32'hA00);
      check("bp_release_fe_rdy", {31'd0, fe_req_ready}, 32'd1);
      tick();
      check("bp_reload_valid", {31'd0, sram_wr_valid}, 32'd1);
      check("bp_reload_xbar", sram_xbar, 32'h900);
      check("bp_reload_streak", {28'd0, fe_streak}, 32'd2);

      // Idle: slot drains, streak holds
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      tick();
      check("idle_valid", {31'd0, sram_wr_valid}, 32'd0);
      check("idle_streak", {28'd0, fe_streak}, 32'd2);

      // Backend alone wins and clears streak
      drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'hB0B);
      check("be_only_rdy", {31'd0, be_req_ready}, 32'd1);
      tick();
      check("be_only_src", {31'd0, sram_wr_src}, 32'd1);
      check("be_only_row", {31'd0, sram_row_or_col}, 32'd1);
      check("be_only_streak", {28'd0, fe_streak}, 32'd0);

      // Reset mid-transfer with a stalled slot and nonzero streak
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hC00, 32'hD00);
      tick();
      check("pre_rst_streak", {28'd0, fe_streak}, 32'd1);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hC01, 32'hD01);
      n_rst = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, sram_wr_valid}, 32'd0);
      check("mid_rst_streak", {28'd0, fe_streak}, 32'd0);
      check("mid_rst_fe_rdy", {31'd0, fe_req_ready}, 32'd0);
      check("mid_rst_be_rdy", {31'd0, be_req_ready}, 32'd0);
      tick();
      check("mid_rst_hold", {31'd0, sram_wr_valid}, 32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      tick();
      check("post_rst_valid", {31'd0, sram_wr_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sram_write_arbiter.md
Name: sram_write_arbiter

Overview:
Shares the single scratchpad SRAM write port between two requesters: the frontend write path (vector/tensor core stores) and the backend SRAM write request queue (DRAM fill data). Frontend has default priority. A starvation counter and the backend queue-full flag force backend grants so DRAM fills keep draining. Output is a single registered request slot with a valid/ready handshake toward the SRAM bank controller.

Parameters:
XBAR_W, 32, width of the crossbar descriptor carried with each write
DATA_W, 256, width of write data
MAX_FE_STREAK, 4, max consecutive frontend grants while backend is waiting (1..15)

Ports:
clk  input  1  clock
n_rst  input  1  asynchronous active-low reset
fe_req_valid  input  1  frontend write request valid
fe_req_ready  output  1  frontend request accepted this cycle
fe_row_or_col  input  1  frontend access orientation
fe_xbar  input  XBAR_W  frontend crossbar descriptor
fe_wdata  input  DATA_W  frontend write data
be_req_valid  input  1  backend (write request queue) has a latched request
be_req_ready  output  1  backend request accepted this cycle (drives the queue's accepted/pop)
be_row_or_col  input  1  backend access orientation
be_xbar  input  XBAR_W  backend crossbar descriptor
be_wdata  input  DATA_W  backend write data
be_queue_full  input  1  backend queue full; forces backend priority
sram_wr_valid  output  1  write request presented to SRAM
sram_wr_ready  input  1  SRAM accepts presented request
sram_wr_src  output  1  owner of presented request: 0 frontend, 1 backend
sram_row_or_col  output  1  presented orientation
sram_xbar  output  XBAR_W  presented crossbar descriptor
sram_wdata  output  DATA_W  presented write data
fe_streak  output  4  current consecutive-frontend-grant count (debug)

Behaviour:
- Reset: sram_wr_valid=0, sram_wr_src=0, sram_row_or_col=0, sram_xbar=0, sram_wdata=0, fe_streak=0. fe_req_ready/be_req_ready are combinational and 0 while n_rst low.
- Slot free condition: slot_free = !sram_wr_valid || sram_wr_ready (full-throughput; a drained slot reloads in the same cycle).
- Grant (combinational, only when slot_free):
  - be_force = be_req_valid && (be_queue_full || fe_streak >= MAX_FE_STREAK).
  - If be_force: grant backend.
  - Else if fe_req_valid: grant frontend.
  - Else if be_req_valid: grant backend.
  - Else: no grant.
- At most one of fe_req_ready/be_req_ready is high per cycle. Each is high only when its valid is high and it wins. Ready never depends on the other side's ready.
- On grant (posedge): the slot loads the winner's row_or_col, xbar and wdata. sram_wr_valid<=1, sram_wr_src<=winner. Latency from request to sram_wr_valid is 1 cycle.
- On sram_wr_ready with no new grant: sram_wr_valid<=0. Payload registers hold their values and are don't-care.
- While sram_wr_valid && !sram_wr_ready: slot payload and src are stable. No grants are issued. Both readies stay 0.
- fe_streak update, on grant only:
  - Frontend granted while be_req_valid: fe_streak+1, saturating at 15.
  - Frontend granted with no backend waiting: 0.
  - Backend granted: 0.
  - Otherwise: hold.
- Simultaneous slot drain and new request: the slot reloads with no bubble (back-to-back valid).
- Both requesters valid every cycle, SRAM always ready: grant pattern is MAX_FE_STREAK frontend grants then 1 backend grant, repeating.
- be_queue_full overrides the streak. The backend wins every free slot while full and be_req_valid.
- Asynchronous reset mid-transfer drops the pending slot. No replay.

Test Plan:
- Reset: assert n_rst=0 mid-operation with sram_wr_valid=1 -> sram_wr_valid=0 and fe_streak=0 immediately; both readies 0 until release.
- Single frontend: fe_req_valid=1 for one cycle with xbar=0x12, SRAM ready -> fe_req_ready=1 that cycle; next cycle sram_wr_valid=1, src=0, sram_xbar=0x12; cleared the following cycle.
- Starvation, MAX_FE_STREAK=4: both valid continuously, SRAM ready -> grant sequence F,F,F,F,B,F,F,F,F,B; fe_streak counts 1,2,3,4 then 0.
- Queue full: both valid, be_queue_full=1 for 3 cycles -> 3 consecutive backend grants; frontend resumes when full drops.
- Backpressure: sram_wr_ready=0 for 5 cycles with both valid -> slot contents stable, no readies asserted; on ready=1, same-cycle grant and next-cycle reload with sram_wr_valid staying 1.
- Idle: no valids with slot draining -> sram_wr_valid falls to 0; fe_streak holds its value.
